// File: rtl/miriscv_mem_arbiter_if.sv
// Bus bundle between the two core masters (fetch M0, LSU M1), the arbiter
// and the shared single-port memory. The arbiter uses the slave view; the
// surrounding environment (core, LSU, RAM or a bench) uses the master view.
interface miriscv_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  m0_req;
  logic [ADDR_W-1:0]     m0_addr;
  logic                  m0_gnt;
  logic                  m0_rvalid;
  logic [DATA_W-1:0]     m0_rdata;

  logic                  m1_req;
  logic                  m1_we;
  logic [DATA_W/8-1:0]   m1_be;
  logic [ADDR_W-1:0]     m1_addr;
  logic [DATA_W-1:0]     m1_wdata;
  logic                  m1_gnt;
  logic                  m1_rvalid;
  logic [DATA_W-1:0]     m1_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  m0_req, m0_addr,
    input  m1_req, m1_we, m1_be, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output m0_req, m0_addr,
    output m1_req, m1_we, m1_be, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/miriscv_mem_arbiter.sv
// Two-master arbiter for the unified instruction/data RAM. One transaction
// is outstanding at a time; a new one may issue on the response cycle of the
// previous, giving one access per MEM_LATENCY cycles. LSU has priority, but
// the fetch port wins after STARVE_MAX consecutive LSU grants it waited on.
//
// state | meaning
// IDLE  | no transaction outstanding, issue allowed
// BUSY  | waiting for memory data; cnt_q==1 is the response cycle
module miriscv_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  miriscv_mem_arbiter_if.slave  bus
);

  localparam int CNT_W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam int STV_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] LAT_LD  = CNT_W'(MEM_LATENCY);
  localparam logic [STV_W-1:0] STV_TOP = STV_W'(STARVE_MAX);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STV_W-1:0]    starve_q, starve_d;
  logic                owner_q, owner_d;   // 0 = M0 (fetch), 1 = M1 (LSU)
  logic                we_q, we_d;

  logic                resp, can_issue, gnt0, gnt1;
  logic [ADDR_W-1:0]   addr_mux;
  logic [DATA_W/8-1:0] be_mux;
  logic [DATA_W-1:0]   wdata_mux;

  // State, latency counter, starve counter and owner registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      starve_q <= '0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
    end
  end

  // Issue window, arbitration, next-state and counter updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    starve_d  = starve_q;
    owner_d   = owner_q;
    we_d      = we_q;
    resp      = 1'b0;
    can_issue = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;

    case (state_q)
      IDLE:    can_issue = rst_n_i;
      BUSY: begin
        resp      = (cnt_q == CNT_W'(1));
        can_issue = rst_n_i && resp;
      end
      default: can_issue = 1'b0;
    endcase

    // Fetch wins when alone, or when the LSU has starved it long enough.
    if (can_issue && bus.m0_req && (!bus.m1_req || starve_q == STV_TOP)) begin
      gnt0 = 1'b1;
    end else if (can_issue && bus.m1_req) begin
      gnt1 = 1'b1;
    end

    if (gnt0 || gnt1) begin
      state_d = BUSY;
      cnt_d   = LAT_LD;
      owner_d = gnt1;
      we_d    = gnt1 && bus.m1_we;
    end else if (resp) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    if (!bus.m0_req || gnt0) begin
      starve_d = '0;
    end else if (gnt1 && starve_q != STV_TOP) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  // Memory-side payload mux; idle cycles drive zeros.
  always_comb begin
    addr_mux  = '0;
    be_mux    = '0;
    wdata_mux = '0;
    if (gnt1) begin
      addr_mux  = bus.m1_addr;
      be_mux    = bus.m1_be;
      wdata_mux = bus.m1_wdata;
    end else if (gnt0) begin
      addr_mux  = bus.m0_addr;
      be_mux    = '1;
    end
  end

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.mem_req   = gnt0 || gnt1;
  assign bus.mem_we    = gnt1 && bus.m1_we;
  assign bus.mem_be    = be_mux;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;

  // Response goes only to the owner; write acks return zero data.
  assign bus.m0_rvalid = rst_n_i && resp && !owner_q;
  assign bus.m1_rvalid = rst_n_i && resp && owner_q;
  assign bus.m0_rdata  = (bus.m0_rvalid && !we_q) ? bus.mem_rdata : '0;
  assign bus.m1_rdata  = (bus.m1_rvalid && !we_q) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Bench for miriscv_mem_arbiter: two instances (latency 1 and 3), each with a
// behavioural RAM. Directed scenarios first, then random traffic checked
// against a transaction-level model (one outstanding access, due cycle = issue
// cycle + latency, starvation counted as plain integers).
module tb_miriscv_mem_arbiter;
  localparam int SMAX = 4;

  typedef struct {
    logic        m0_req;
    logic [31:0] m0_addr;
    logic        m1_req;
    logic        m1_we;
    logic [3:0]  m1_be;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
  } drv_t;

  typedef struct {
    logic        g0, g1, rv0, rv1, mreq, mwe;
    logic [31:0] rd0, rd1, maddr, mwdata;
    logic [3:0]  mbe;
  } obs_t;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_i = ~clk_i;

  miriscv_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  miriscv_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  miriscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_MAX(SMAX))
    u_dut1 (.clk_i(clk_i), .rst_n_i(rst_n), .bus(bus1));
  miriscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_MAX(SMAX))
    u_dut3 (.clk_i(clk_i), .rst_n_i(rst_n), .bus(bus3));

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [31:0] init_word(int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0003);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural RAMs: capture at the issue cycle, present data from the next edge on.
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] nxt1, nxt3;
  logic        ld1 = 1'b0, ld3 = 1'b0;

  always @(negedge clk_i) begin
    ld1  = bus1.mem_req && !bus1.mem_we;
    nxt1 = mem1[bus1.mem_addr[9:2]];
    if (bus1.mem_req && bus1.mem_we)
      for (int b = 0; b < 4; b++)
        if (bus1.mem_be[b]) mem1[bus1.mem_addr[9:2]][8*b +: 8] = bus1.mem_wdata[8*b +: 8];
    ld3  = bus3.mem_req && !bus3.mem_we;
    nxt3 = mem3[bus3.mem_addr[9:2]];
    if (bus3.mem_req && bus3.mem_we)
      for (int b = 0; b < 4; b++)
        if (bus3.mem_be[b]) mem3[bus3.mem_addr[9:2]][8*b +: 8] = bus3.mem_wdata[8*b +: 8];
  end

  always @(posedge clk_i) begin
    if (ld1) bus1.mem_rdata <= nxt1;
    if (ld3) bus3.mem_rdata <= nxt3;
  end

  function automatic drv_t idle();
    drv_t d;
    d.m0_req = 1'b0; d.m0_addr = '0; d.m1_req = 1'b0; d.m1_we = 1'b0;
    d.m1_be = '0; d.m1_addr = '0; d.m1_wdata = '0;
    return d;
  endfunction

  task automatic apply(input int k, input drv_t d);
    if (k == 0) begin
      bus1.m0_req = d.m0_req; bus1.m0_addr = d.m0_addr; bus1.m1_req = d.m1_req;
      bus1.m1_we = d.m1_we; bus1.m1_be = d.m1_be; bus1.m1_addr = d.m1_addr;
      bus1.m1_wdata = d.m1_wdata;
    end else begin
      bus3.m0_req = d.m0_req; bus3.m0_addr = d.m0_addr; bus3.m1_req = d.m1_req;
      bus3.m1_we = d.m1_we; bus3.m1_be = d.m1_be; bus3.m1_addr = d.m1_addr;
      bus3.m1_wdata = d.m1_wdata;
    end
  endtask

  function automatic obs_t observe(input int k);
    obs_t o;
    if (k == 0) begin
      o.g0 = bus1.m0_gnt; o.g1 = bus1.m1_gnt; o.rv0 = bus1.m0_rvalid; o.rv1 = bus1.m1_rvalid;
      o.rd0 = bus1.m0_rdata; o.rd1 = bus1.m1_rdata; o.mreq = bus1.mem_req; o.mwe = bus1.mem_we;
      o.mbe = bus1.mem_be; o.maddr = bus1.mem_addr; o.mwdata = bus1.mem_wdata;
    end else begin
      o.g0 = bus3.m0_gnt; o.g1 = bus3.m1_gnt; o.rv0 = bus3.m0_rvalid; o.rv1 = bus3.m1_rvalid;
      o.rd0 = bus3.m0_rdata; o.rd1 = bus3.m1_rdata; o.mreq = bus3.mem_req; o.mwe = bus3.mem_we;
      o.mbe = bus3.mem_be; o.maddr = bus3.mem_addr; o.mwdata = bus3.mem_wdata;
    end
    return o;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Transaction-level reference state for the random phase.
  int          lat [2];
  bit          busy [2];
  int          due [2];
  bit          own [2];
  logic [31:0] expd [2];
  int          stv [2];
  bit          p0 [2], p1 [2];
  drv_t        cur [2];
  logic [31:0] refm [2][256];
  int          cyc;

  task automatic model_cycle(input int k);
    obs_t o;
    drv_t d;
    bit resp, can, e0, e1;
    logic [31:0] a;
    int idx;
    o = observe(k);
    d = cur[k];
    resp = busy[k] && (due[k] == cyc);
    can  = !busy[k] || resp;
    e0   = can && d.m0_req && (!d.m1_req || stv[k] == SMAX);
    e1   = can && d.m1_req && !e0;
    check("rnd_gnt", {o.g1, o.g0}, {e1, e0});
    check("rnd_mem_req", o.mreq, e0 | e1);
    if (e1) check("rnd_mem_ctl_m1", {o.mwe, o.mbe}, {d.m1_we, d.m1_be});
    if (e0) check("rnd_mem_ctl_m0", {o.mwe, o.mbe}, 5'b0_1111);
    check("rnd_rvalid", {o.rv1, o.rv0}, {resp && own[k], resp && !own[k]});
    check("rnd_rdata", {o.rd1, o.rd0},
          {(resp && own[k]) ? expd[k] : 32'h0, (resp && !own[k]) ? expd[k] : 32'h0});
    if (resp) busy[k] = 1'b0;
    if (!d.m0_req || e0) stv[k] = 0;
    else if (e1 && stv[k] < SMAX) stv[k]++;
    if (e0 || e1) begin
      busy[k] = 1'b1;
      due[k]  = cyc + lat[k];
      own[k]  = e1;
      a       = e1 ? d.m1_addr : d.m0_addr;
      idx     = int'(a[9:2]);
      if (e1 && d.m1_we) begin
        expd[k] = '0;
        for (int b = 0; b < 4; b++)
          if (d.m1_be[b]) refm[k][idx][8*b +: 8] = d.m1_wdata[8*b +: 8];
      end else begin
        expd[k] = refm[k][idx];
      end
    end
    if (o.g0) p0[k] = 1'b0;
    if (o.g1) p1[k] = 1'b0;
  endtask

  initial begin
    drv_t d;
    obs_t o;
    logic [31:0] w;
    logic [9:0]  order;

    for (int i = 0; i < 256; i++) begin
      mem1[i] = init_word(i);
      mem3[i] = init_word(i);
      refm[0][i] = init_word(i);
      refm[1][i] = init_word(i);
    end
    bus1.mem_rdata = '0;
    bus3.mem_rdata = '0;
    apply(0, idle());
    apply(1, idle());
    rst_n = 1'b0;

    // Reset held with both requests high, then a single fetch.
    d = idle(); d.m0_req = 1'b1; d.m1_req = 1'b1; d.m0_addr = 32'h10; d.m1_addr = 32'h14;
    apply(0, d);
    #1;
    repeat (3) begin
      @(negedge clk_i);
      o = observe(0);
      check("t1_rst_quiet", {o.g0, o.g1, o.rv0, o.rv1, o.mreq, o.mwe}, 6'b0);
      step();
    end
    rst_n = 1'b1;
    d = idle(); d.m0_req = 1'b1; d.m0_addr = 32'h10;
    apply(0, d);
    @(negedge clk_i);
    o = observe(0);
    check("t1_gnt", {o.g1, o.g0}, 2'b01);
    check("t1_mem_ctl", {o.mreq, o.mwe, o.mbe}, 6'b1_0_1111);
    check("t1_mem_addr", o.maddr, 32'h10);
    step();
    apply(0, idle());
    @(negedge clk_i);
    o = observe(0);
    check("t1_rvalid", {o.rv1, o.rv0}, 2'b01);
    check("t1_rdata", o.rd0, init_word(4));
    check("t1_m1_quiet", o.rd1, 32'h0);

    // LSU partial write, its ack, then read-back.
    step();
    d = idle(); d.m1_req = 1'b1; d.m1_we = 1'b1; d.m1_be = 4'b0011;
    d.m1_addr = 32'h100; d.m1_wdata = 32'hDEAD_BEEF;
    apply(0, d);
    @(negedge clk_i);
    o = observe(0);
    check("t2_gnt", {o.g1, o.g0}, 2'b10);
    check("t2_mem_ctl", {o.mreq, o.mwe, o.mbe}, 6'b1_1_0011);
    check("t2_mem_addr", o.maddr, 32'h100);
    check("t2_mem_wdata", o.mwdata, 32'hDEAD_BEEF);
    step();
    apply(0, idle());
    @(negedge clk_i);
    o = observe(0);
    check("t2_rvalid", {o.rv1, o.rv0}, 2'b10);
    check("t2_wr_rdata", o.rd1, 32'h0);
    check("t2_m0_untouched", {o.rv0, o.rd0}, 33'h0);
    step();
    d = idle(); d.m1_req = 1'b1; d.m1_addr = 32'h100;
    apply(0, d);
    @(negedge clk_i);
    o = observe(0);
    check("t2_rd_gnt", {o.g1, o.g0}, 2'b10);
    step();
    apply(0, idle());
    @(negedge clk_i);
    o = observe(0);
    w = init_word(64);
    check("t2_readback", o.rd1, {w[31:16], 16'hBEEF});

    // Both masters held high: starvation limit forces every fifth grant to M0.
    step();
    d = idle(); d.m0_req = 1'b1; d.m0_addr = 32'h20; d.m1_req = 1'b1; d.m1_addr = 32'h40;
    apply(0, d);
    order = 10'b01111_01111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      o = observe(0);
      check("t3_order", {o.g1, o.g0}, order[i] ? 2'b10 : 2'b01);
      if (i > 0) check("t3_rvalid", {o.rv1, o.rv0}, order[i-1] ? 2'b10 : 2'b01);
      step();
    end
    apply(0, idle());
    @(negedge clk_i);
    o = observe(0);
    check("t3_last_rvalid", {o.rv1, o.rv0}, order[9] ? 2'b10 : 2'b01);
    step();

    // Latency 3: back-to-back fetches issue every third cycle.
    d = idle(); d.m0_req = 1'b1; d.m0_addr = 32'h0;
    apply(1, d);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk_i);
      o = observe(1);
      check("t4_gnt", {o.g1, o.g0}, (c == 0 || c == 3) ? 2'b01 : 2'b00);
      check("t4_mem_req", o.mreq, (c == 0 || c == 3));
      check("t4_rvalid", {o.rv1, o.rv0}, (c == 3 || c == 6) ? 2'b01 : 2'b00);
      if (c == 3) begin
        check("t4_rdata0", o.rd0, init_word(0));
        check("t4_addr1", o.maddr, 32'h4);
      end
      if (c == 6) check("t4_rdata1", o.rd0, init_word(1));
      step();
      if (c == 0) begin d.m0_addr = 32'h4; apply(1, d); end
      if (c == 3) apply(1, idle());
    end

    // Reset during an in-flight LSU read abandons it.
    d = idle(); d.m1_req = 1'b1; d.m1_addr = 32'h8;
    apply(1, d);
    @(negedge clk_i);
    o = observe(1);
    check("t5_gnt", {o.g1, o.g0}, 2'b10);
    step();
    rst_n = 1'b0;
    apply(1, idle());
    @(negedge clk_i);
    o = observe(1);
    check("t5_rst_quiet", {o.g0, o.g1, o.rv0, o.rv1, o.mreq}, 5'b0);
    step();
    rst_n = 1'b1;
    d = idle(); d.m0_req = 1'b1; d.m0_addr = 32'hC;
    apply(1, d);
    @(negedge clk_i);
    o = observe(1);
    check("t5_idle_gnt", {o.g1, o.g0}, 2'b01);
    check("t5_rvalid0", {o.rv1, o.rv0}, 2'b00);
    step();
    apply(1, idle());
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_i);
      o = observe(1);
      check("t5_no_m1_rvalid", {o.rv1, o.rv0}, (c == 3) ? 2'b01 : 2'b00);
      if (c == 3) check("t5_rdata", o.rd0, init_word(3));
      step();
    end

    // Random traffic on both instances against the transaction model.
    apply(0, idle());
    apply(1, idle());
    step();
    step();
    lat[0] = 1;
    lat[1] = 3;
    for (int k = 0; k < 2; k++) begin
      busy[k] = 1'b0; due[k] = 0; own[k] = 1'b0; expd[k] = '0; stv[k] = 0;
      p0[k] = 1'b0; p1[k] = 1'b0; cur[k] = idle();
    end
    cyc = 0;
    for (int n = 0; n < 10006; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (n >= 10000) begin
          cur[k] = idle(); p0[k] = 1'b0; p1[k] = 1'b0;
        end else begin
          if (!p0[k]) begin
            cur[k].m0_req  = ($urandom_range(0, 99) < 60);
            cur[k].m0_addr = 32'($urandom_range(0, 31)) << 2;
            p0[k] = cur[k].m0_req;
          end
          if (!p1[k]) begin
            cur[k].m1_req   = ($urandom_range(0, 99) < 60);
            cur[k].m1_we    = 1'($urandom_range(0, 1));
            cur[k].m1_be    = 4'($urandom_range(0, 15));
            cur[k].m1_addr  = 32'($urandom_range(0, 31)) << 2;
            cur[k].m1_wdata = $urandom;
            p1[k] = cur[k].m1_req;
          end
        end
        apply(k, cur[k]);
      end
      @(negedge clk_i);
      model_cycle(0);
      model_cycle(1);
      cyc++;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
